// File: rtl/abp_packet_rx.sv
// ============================================================================
// Module   : abp_packet_rx
// Function : ABP packet receiver. It takes fixed-size frames from an
//            AXI-Stream MAC and emits the sequence value and alternating bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module abp_packet_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int VALUE_SIZE  = 4,
  parameter int PACKET_SIZE = 64
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_eth_rx_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_eth_rx_tdata,
  input  logic                    s_eth_rx_tlast,
  output logic                    s_eth_rx_tready,
  output logic                    m_abp_valid,
  input  logic                    m_abp_ready,
  output logic [VALUE_SIZE*8-1:0] m_abp_value,
  output logic                    m_abp_bit,
  output logic                    busy,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int c_VW = VALUE_SIZE * 8;
  localparam int c_CW = $clog2(PACKET_SIZE);
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(PACKET_SIZE - 1);
  localparam logic [c_CW-1:0] c_VBYTES = c_CW'(VALUE_SIZE);

  localparam logic [1:0] c_RECV = 2'd0;
  localparam logic [1:0] c_DROP = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_tready;
  logic [c_VW-1:0] r_value;
  logic            r_bit;
  logic            r_err_short;
  logic            r_err_long;

  logic [1:0]      w_state_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            w_short;
  logic            w_long;
  logic            w_accept;
  logic [c_VW-1:0] w_value_shift;

  assign w_accept = s_eth_rx_tvalid & r_tready;

  // Value bytes arrive MSB first, so each new byte enters at the bottom.
  generate
    if (VALUE_SIZE > 1) begin : g_shift_multi
      assign w_value_shift = {r_value[c_VW-DATA_WIDTH-1:0], s_eth_rx_tdata};
    end else begin : g_shift_single
      assign w_value_shift = s_eth_rx_tdata;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short     = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      c_RECV: begin
        if (w_accept) begin
          if (s_eth_rx_tlast) begin
            w_cnt_nxt = '0;
            if (r_cnt == c_LAST) w_state_nxt = c_HOLD;
            else                 w_short     = 1'b1;
          end else if (r_cnt == c_LAST) begin
            w_state_nxt = c_DROP;
            w_cnt_nxt   = '0;
            w_long      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      c_DROP: begin
        if (w_accept && s_eth_rx_tlast) begin
          w_state_nxt = c_RECV;
          w_cnt_nxt   = '0;
        end
      end
      c_HOLD: begin
        if (m_abp_ready) w_state_nxt = c_RECV;
      end
      default: begin
        w_state_nxt = c_RECV;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state     <= c_RECV;
      r_cnt       <= '0;
      r_tready    <= 1'b0;
      r_value     <= '0;
      r_bit       <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Registered from the next state so tready never depends on m_abp_ready combinationally.
      r_tready    <= (w_state_nxt != c_HOLD);
      r_err_short <= w_short;
      r_err_long  <= w_long;
      if (r_state == c_RECV && w_accept) begin
        if (r_cnt < c_VBYTES) r_value <= w_value_shift;
        if (r_cnt == c_LAST)  r_bit   <= s_eth_rx_tdata[0];
      end
    end
  end

  assign s_eth_rx_tready = r_tready;
  assign m_abp_valid     = (r_state == c_HOLD);
  assign m_abp_value     = r_value;
  assign m_abp_bit       = r_bit;
  assign busy            = (r_state == c_HOLD) || (r_state == c_DROP) || (r_cnt != '0);
  assign err_short       = r_err_short;
  assign err_long        = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_abp_packet_rx.sv
// ============================================================================
// Module   : tb_abp_packet_rx
// Function : Directed self-checking bench for abp_packet_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abp_packet_rx;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_eth_rx_tvalid = 1'b0;
  logic [7:0]  s_eth_rx_tdata = 8'h00;
  logic        s_eth_rx_tlast = 1'b0;
  logic        s_eth_rx_tready;
  logic        m_abp_valid;
  logic        m_abp_ready = 1'b1;
  logic [31:0] m_abp_value;
  logic        m_abp_bit;
  logic        busy;
  logic        err_short;
  logic        err_long;

  int n_checks = 0;
  int n_errors = 0;

  int          hs_cnt = 0;
  int          short_cnt = 0;
  int          long_cnt = 0;
  logic [31:0] last_val = '0;
  logic        last_bit = 1'b0;

  always #5 aclk = ~aclk;

  abp_packet_rx #(
    .DATA_WIDTH (8),
    .VALUE_SIZE (4),
    .PACKET_SIZE(64)
  ) u_dut (
    .aclk           (aclk),
    .resetn         (resetn),
    .s_eth_rx_tvalid(s_eth_rx_tvalid),
    .s_eth_rx_tdata (s_eth_rx_tdata),
    .s_eth_rx_tlast (s_eth_rx_tlast),
    .s_eth_rx_tready(s_eth_rx_tready),
    .m_abp_valid    (m_abp_valid),
    .m_abp_ready    (m_abp_ready),
    .m_abp_value    (m_abp_value),
    .m_abp_bit      (m_abp_bit),
    .busy           (busy),
    .err_short      (err_short),
    .err_long       (err_long)
  );

  // Output monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    if (resetn) begin
      if (m_abp_valid && m_abp_ready) begin
        hs_cnt   <= hs_cnt + 1;
        last_val <= m_abp_value;
        last_bit <= m_abp_bit;
      end
      if (err_short) short_cnt <= short_cnt + 1;
      if (err_long)  long_cnt  <= long_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge aclk);
  endtask

  // Drives one byte from a falling edge; returns after the rising edge that accepts it.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int wait_cnt;
    for (int g = 0; g < gap; g++) begin
      @(negedge aclk);
      s_eth_rx_tvalid = 1'b0;
    end
    @(negedge aclk);
    s_eth_rx_tvalid = 1'b1;
    s_eth_rx_tdata  = d;
    s_eth_rx_tlast  = last;
    wait_cnt = 0;
    while (!s_eth_rx_tready && wait_cnt < 50) begin
      @(negedge aclk);
      wait_cnt++;
    end
    if (wait_cnt >= 50) chk("tready_timeout", 64'(s_eth_rx_tready), 64'd1);
    @(posedge aclk);
  endtask

  task automatic send_frame(input int n, input logic [31:0] val, input logic [7:0] lastb,
                            input logic gaps, input logic with_last);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (i < 4)        d = val[31 - 8*i -: 8];
      else if (i == 63) d = lastb;
      else              d = 8'(i);
      send_byte(d, with_last && (i == n - 1), gaps ? int'($urandom_range(0, 1)) : 0);
    end
  endtask

  task automatic end_frame();
    @(negedge aclk);
    s_eth_rx_tvalid = 1'b0;
    s_eth_rx_tlast  = 1'b0;
  endtask

  int hs0;
  int sh0;
  int lg0;

  initial begin
    // Reset state
    resetn = 1'b0;
    idle(3);
    chk("rst_tready", 64'(s_eth_rx_tready), 64'd0);
    chk("rst_valid",  64'(m_abp_valid), 64'd0);
    chk("rst_value",  64'(m_abp_value), 64'd0);
    chk("rst_bit",    64'(m_abp_bit), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_errs",   64'({err_short, err_long}), 64'd0);
    resetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_rst", 64'(s_eth_rx_tready), 64'd1);

    // Nominal frame, downstream always ready
    hs0 = hs_cnt;
    send_frame(64, 32'h0000012A, 8'h01, 1'b0, 1'b1);
    end_frame();
    chk("nom_valid", 64'(m_abp_valid), 64'd1);
    chk("nom_value", 64'(m_abp_value), 64'h12A);
    chk("nom_bit",   64'(m_abp_bit), 64'd1);
    idle(3);
    chk("nom_hs",    64'(hs_cnt - hs0), 64'd1);
    chk("nom_valid_low", 64'(m_abp_valid), 64'd0);
    chk("nom_errs",  64'(short_cnt + long_cnt), 64'd0);
    chk("nom_busy",  64'(busy), 64'd0);

    // Backpressure: held for 10 cycles
    m_abp_ready = 1'b0;
    hs0 = hs_cnt;
    send_frame(64, 32'h0000012A, 8'hFE, 1'b0, 1'b1);
    end_frame();
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid",  64'(m_abp_valid), 64'd1);
      chk("hold_value",  64'(m_abp_value), 64'h12A);
      chk("hold_bit",    64'(m_abp_bit), 64'd0);
      chk("hold_tready", 64'(s_eth_rx_tready), 64'd0);
      chk("hold_busy",   64'(busy), 64'd1);
      @(negedge aclk);
    end
    m_abp_ready = 1'b1;
    @(negedge aclk);
    chk("rel_valid",  64'(m_abp_valid), 64'd0);
    chk("rel_tready", 64'(s_eth_rx_tready), 64'd1);
    idle(1);
    chk("rel_hs",     64'(hs_cnt - hs0), 64'd1);
    chk("rel_hs_bit", 64'(last_bit), 64'd0);

    // Short frame, then a good one
    hs0 = hs_cnt; sh0 = short_cnt;
    send_frame(20, 32'h11223344, 8'h00, 1'b0, 1'b1);
    end_frame();
    chk("short_pulse_now", 64'(err_short), 64'd1);
    chk("short_busy", 64'(busy), 64'd0);
    send_frame(64, 32'hDEADBEEF, 8'h03, 1'b0, 1'b1);
    end_frame();
    idle(2);
    chk("short_cnt", 64'(short_cnt - sh0), 64'd1);
    chk("short_hs",  64'(hs_cnt - hs0), 64'd1);
    chk("short_next_val", 64'(last_val), 64'hDEADBEEF);
    chk("short_next_bit", 64'(last_bit), 64'd1);

    // Long frame, then a good one
    hs0 = hs_cnt; lg0 = long_cnt;
    send_frame(64, 32'hCAFEF00D, 8'h01, 1'b0, 1'b0);
    @(negedge aclk);
    chk("long_pulse_now", 64'(err_long), 64'd1);
    chk("long_busy", 64'(busy), 64'd1);
    for (int i = 64; i < 80; i++) send_byte(8'(i), i == 79, 0);
    end_frame();
    chk("long_hs_none", 64'(hs_cnt - hs0), 64'd0);
    send_frame(64, 32'h01020304, 8'h00, 1'b0, 1'b1);
    end_frame();
    idle(2);
    chk("long_cnt", 64'(long_cnt - lg0), 64'd1);
    chk("long_hs",  64'(hs_cnt - hs0), 64'd1);
    chk("long_next_val", 64'(last_val), 64'h01020304);
    chk("long_next_bit", 64'(last_bit), 64'd0);

    // Random tvalid gaps
    hs0 = hs_cnt;
    send_frame(64, 32'h0000012A, 8'h01, 1'b1, 1'b1);
    end_frame();
    idle(2);
    chk("gap_hs",  64'(hs_cnt - hs0), 64'd1);
    chk("gap_val", 64'(last_val), 64'h12A);
    chk("gap_bit", 64'(last_bit), 64'd1);

    // Reset mid-frame
    hs0 = hs_cnt;
    send_frame(30, 32'hAAAAAAAA, 8'h01, 1'b0, 1'b0);
    @(negedge aclk);
    s_eth_rx_tvalid = 1'b0;
    resetn = 1'b0;
    idle(2);
    chk("midrst_busy",  64'(busy), 64'd0);
    chk("midrst_value", 64'(m_abp_value), 64'd0);
    resetn = 1'b1;
    send_frame(64, 32'h55667788, 8'h01, 1'b0, 1'b1);
    end_frame();
    idle(2);
    chk("midrst_hs",  64'(hs_cnt - hs0), 64'd1);
    chk("midrst_val", 64'(last_val), 64'h55667788);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/abp_packet_rx.md
ABP_PACKET_RX -- requirements
Module: abp_packet_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the RX AXI-Stream tdata in bits; only 8 is supported.
REQ-002 Parameter VALUE_SIZE, default 4: number of sequence-value bytes at the packet head.
REQ-003 Parameter PACKET_SIZE, default 64: bytes per ABP packet; must satisfy PACKET_SIZE > VALUE_SIZE.
REQ-004 aclk  input  1  clock; all logic is on the rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 s_eth_rx_tvalid  input  1  byte valid from the MAC.
REQ-007 s_eth_rx_tdata  input  DATA_WIDTH  packet byte.
REQ-008 s_eth_rx_tlast  input  1  last byte of the frame.
REQ-009 s_eth_rx_tready  output  1  block accepts a byte.
REQ-010 m_abp_valid  output  1  decoded hyperdata valid.
REQ-011 m_abp_ready  input  1  downstream accepts the hyperdata.
REQ-012 m_abp_value  output  VALUE_SIZE*8  decoded sequence value.
REQ-013 m_abp_bit  output  1  decoded alternating bit.
REQ-014 busy  output  1  high while a frame is partially received or hyperdata is pending.
REQ-015 err_short  output  1  one-cycle pulse when a frame ends before PACKET_SIZE bytes.
REQ-016 err_long  output  1  one-cycle pulse when byte PACKET_SIZE-1 arrives without tlast.

Function
REQ-017 FSM states: RECV, DROP and HOLD; a byte is accepted on a cycle where s_eth_rx_tvalid and s_eth_rx_tready are both high.
REQ-018 s_eth_rx_tready is 1 in RECV and DROP, and 0 in HOLD; it is a register output with no combinational path from m_abp_ready.
REQ-019 Byte counter width is $clog2(PACKET_SIZE); it advances by 1 per accepted byte in RECV and clears to 0 on entry to RECV.
REQ-020 Bytes at counter 0..VALUE_SIZE-1 are shifted into the value register MSB first (byte 0 lands in bits [VALUE_SIZE*8-1 -: 8]).
REQ-021 Bytes at counter VALUE_SIZE..PACKET_SIZE-2 are accepted and ignored.
REQ-022 At counter PACKET_SIZE-1, tdata[0] is latched as the bit and tdata[7:1] is ignored.
REQ-023 In RECV, an accepted byte with tlast at counter PACKET_SIZE-1 moves the FSM to HOLD; m_abp_valid goes high on the next cycle, with value and bit stable.
REQ-024 In RECV, an accepted byte with tlast at counter < PACKET_SIZE-1 pulses err_short on the next cycle, keeps the FSM in RECV and clears the counter; m_abp_valid is not asserted.
REQ-025 In RECV, an accepted byte without tlast at counter PACKET_SIZE-1 pulses err_long on the next cycle and moves the FSM to DROP.
REQ-026 DROP accepts and discards bytes; an accepted byte with tlast returns the FSM to RECV with the counter at 0.
REQ-027 In HOLD, m_abp_valid, m_abp_value and m_abp_bit stay constant until m_abp_ready is high.
REQ-028 On the cycle where m_abp_valid and m_abp_ready are both high, the next state is RECV: m_abp_valid drops and s_eth_rx_tready rises on the following cycle.
REQ-029 m_abp_value is the raw received value; no increment or other arithmetic is applied.
REQ-030 tvalid low stalls the counter and the FSM in any state; there is no timeout.
REQ-031 busy = (state == HOLD) or (state == DROP) or (counter != 0).

Reset
REQ-032 While resetn is low: state = RECV, counter = 0, s_eth_rx_tready = 0, m_abp_valid = 0, m_abp_value = 0, m_abp_bit = 0, busy = 0, err_short = 0, err_long = 0.
REQ-033 s_eth_rx_tready rises on the first cycle after resetn is released.
REQ-034 Reset mid-frame or in HOLD discards all partial or pending data; no hyperdata is emitted for that frame.

Verification
REQ-035 64-byte frame with bytes 0-3 = 00 00 01 2A, byte 63 = 0x01 with tlast, m_abp_ready held high -> one m_abp_valid pulse with value 0x0000012A and bit 1, one cycle after the last byte.
REQ-036 Same frame with byte 63 = 0xFE and m_abp_ready low for 10 cycles -> bit 0; valid and value held for 10 cycles; tready stays 0 during the hold; tready returns to 1 one cycle after the handshake.
REQ-037 20-byte frame with tlast on byte 19 -> err_short pulses once; no m_abp_valid; an immediately following valid frame decodes correctly.
REQ-038 80-byte frame with tlast on byte 79 -> err_long pulses once after byte 63; bytes 64-79 are consumed; no m_abp_valid; the next frame decodes correctly.
REQ-039 Valid frame with random tvalid gaps (~50% duty) -> same decoded output as the gap-free case.
REQ-040 resetn low at byte 30 of a frame, then a new full frame -> only the new frame's hyperdata is emitted.
